// File: rtl/gate_sweep_sequencer.sv
// rtl/gate_sweep_sequencer.sv - self-test sweep sequencer for the logic-gate selector datapath
//
// Purpose: on start, drives every gate select (0..6) with every {a,b} pair,
// samples gate_y after SETTLE_CYCLES cycles per vector, reports each gate's
// 4-bit truth table and compares it with the built-in golden tables.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      level-sampled control requests
//   gate_y            datapath output under test
//   gate_a, gate_b    operand drive to the datapath
//   gate_sel          gate select drive
//   busy, done, pass  sweep status; pass valid while done
//   fail_mask         bit g set when gate g mismatched golden
//   tt_valid          one-cycle strobe qualifying tt_sel/tt_bits
//   tt_sel, tt_bits   gate just measured and its table (bit k = y for {a,b}=k)

module gate_sweep_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic [2:0] gate_sel,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask,
   output logic       tt_valid,
   output logic [2:0] tt_sel,
   output logic [3:0] tt_bits
);

   typedef enum logic [1:0] {IDLE, SETTLE, REPORT, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_GATE = 3'd6;

   state_t     state, state_nx;
   logic [2:0] gate, gate_nx;
   logic [1:0] k, k_nx;
   logic [3:0] cnt, cnt_nx;
   logic [3:0] tbl, tbl_nx;
   logic [3:0] cap;

   logic       gate_a_nx, gate_b_nx;
   logic [2:0] gate_sel_nx;
   logic       busy_nx, done_nx, pass_nx;
   logic [6:0] fail_mask_nx;
   logic       tt_valid_nx;
   logic [2:0] tt_sel_nx;
   logic [3:0] tt_bits_nx;

   function automatic logic [3:0] golden(input logic [2:0] g);
      case (g)
         3'd0:    golden = 4'b1000;
         3'd1:    golden = 4'b1110;
         3'd2:    golden = 4'b0011;
         3'd3:    golden = 4'b0111;
         3'd4:    golden = 4'b0001;
         3'd5:    golden = 4'b0110;
         3'd6:    golden = 4'b1001;
         default: golden = 4'b0000;
      endcase
   endfunction

   // Table as it will look once the current sample lands in bit k.
   always_comb begin
      cap    = tbl;
      cap[k] = gate_y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gate      <= 3'd0;
         k         <= 2'd0;
         cnt       <= 4'd0;
         tbl       <= 4'd0;
         gate_a    <= 1'b0;
         gate_b    <= 1'b0;
         gate_sel  <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 7'd0;
         tt_valid  <= 1'b0;
         tt_sel    <= 3'd0;
         tt_bits   <= 4'd0;
      end else begin
         state     <= state_nx;
         gate      <= gate_nx;
         k         <= k_nx;
         cnt       <= cnt_nx;
         tbl       <= tbl_nx;
         gate_a    <= gate_a_nx;
         gate_b    <= gate_b_nx;
         gate_sel  <= gate_sel_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         pass      <= pass_nx;
         fail_mask <= fail_mask_nx;
         tt_valid  <= tt_valid_nx;
         tt_sel    <= tt_sel_nx;
         tt_bits   <= tt_bits_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      gate_nx      = gate;
      k_nx         = k;
      cnt_nx       = cnt;
      tbl_nx       = tbl;
      gate_a_nx    = gate_a;
      gate_b_nx    = gate_b;
      gate_sel_nx  = gate_sel;
      busy_nx      = busy;
      done_nx      = done;
      pass_nx      = pass;
      fail_mask_nx = fail_mask;
      tt_valid_nx  = 1'b0;
      tt_sel_nx    = tt_sel;
      tt_bits_nx   = tt_bits;

      if (abort) begin
         // Abort beats start everywhere and discards any partial results.
         state_nx     = IDLE;
         busy_nx      = 1'b0;
         done_nx      = 1'b0;
         pass_nx      = 1'b0;
         fail_mask_nx = 7'd0;
         gate_a_nx    = 1'b0;
         gate_b_nx    = 1'b0;
         gate_sel_nx  = 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               gate_a_nx   = 1'b0;
               gate_b_nx   = 1'b0;
               gate_sel_nx = 3'd0;
               if (start) begin
                  state_nx     = SETTLE;
                  fail_mask_nx = 7'd0;
                  pass_nx      = 1'b0;
                  done_nx      = 1'b0;
                  busy_nx      = 1'b1;
                  cnt_nx       = 4'd0;
                  gate_nx      = 3'd0;
                  k_nx         = 2'd0;
                  tbl_nx       = 4'd0;
               end
            end
            SETTLE: begin
               if (cnt == CNT_LAST) begin
                  cnt_nx = 4'd0;
                  tbl_nx = cap;
                  if (k == 2'd3) begin
                     // Drive stays at {1,1} through the single REPORT cycle.
                     state_nx           = REPORT;
                     tt_valid_nx        = 1'b1;
                     tt_sel_nx          = gate;
                     tt_bits_nx         = cap;
                     fail_mask_nx[gate] = (cap != golden(gate));
                  end else begin
                     k_nx      = k + 2'd1;
                     gate_a_nx = k_nx[1];
                     gate_b_nx = k_nx[0];
                  end
               end else begin
                  cnt_nx = cnt + 4'd1;
               end
            end
            REPORT: begin
               if (gate == LAST_GATE) begin
                  state_nx    = DONE;
                  busy_nx     = 1'b0;
                  done_nx     = 1'b1;
                  pass_nx     = (fail_mask == 7'd0);
                  gate_a_nx   = 1'b0;
                  gate_b_nx   = 1'b0;
                  gate_sel_nx = 3'd0;
               end else begin
                  state_nx    = SETTLE;
                  gate_nx     = gate + 3'd1;
                  k_nx        = 2'd0;
                  cnt_nx      = 4'd0;
                  tbl_nx      = 4'd0;
                  gate_a_nx   = 1'b0;
                  gate_b_nx   = 1'b0;
                  gate_sel_nx = gate + 3'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
